// File: rtl/rv_imm_pkg.sv
// rv_imm_pkg
//   Shared types and constants for the RISC-V immediate generator.
//   - imm_fmt_t  : decoded instruction format as it leaves the block
//   - OP_*       : major opcodes (instr[6:0]) that carry or imply an immediate
//   - imm_beat_t : one decoded beat sized for the widest configuration
//                  (64-bit immediate, 8-bit tag); narrower builds pack an
//                  exactly-sized payload instead of carrying unused bits
package rv_imm_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_ISH = 3'd2,
    FMT_S   = 3'd3,
    FMT_B   = 3'd4,
    FMT_U   = 3'd5,
    FMT_J   = 3'd6,
    FMT_ILL = 3'd7
  } imm_fmt_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam int MAX_XLEN  = 64;
  localparam int MAX_TAG_W = 8;

  typedef struct packed {
    logic [MAX_XLEN-1:0]  imm;
    imm_fmt_t             fmt;
    logic [MAX_TAG_W-1:0] tag;
  } imm_beat_t;

endpackage

// File: rtl/valid_ready_skid.sv
// valid_ready_skid
//   Two-entry valid/ready pipeline stage: a registered output slot plus a
//   skid slot that catches the beat accepted while the consumer stalls.
//   in_ready is registered (it is simply "skid empty"), so the upstream
//   ready path never sees the downstream out_ready combinationally.
//   Ports:
//     clk, rst_n          clock, async active-low reset (clears both slots)
//     in_valid/in_ready   upstream handshake
//     in_data [W]         upstream payload
//     out_valid/out_ready downstream handshake
//     out_data [W]        downstream payload (stable while stalled)
module valid_ready_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_q;
  logic [W-1:0] out_data_q;
  logic         skid_valid_q;
  logic [W-1:0] skid_data_q;

  logic accept;
  logic load_out;

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  // The output slot may take a new beat whenever it is free or draining.
  assign load_out = ~out_valid_q | out_ready;

  // Skid has priority over the input when the output slot frees up; the
  // input cannot be accepted in that cycle anyway because in_ready is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else if (load_out) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= skid_data_q;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= accept;
        if (accept) begin
          out_data_q <= in_data;
        end
      end
    end else if (accept) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Decodes the instruction format from the opcode and assembles the
//   immediate, extended to XLEN, then registers it through a two-entry
//   valid/ready stage. Decode is purely combinational ahead of the stage,
//   so both slots hold decoded fields rather than raw instruction words.
//   Parameters: XLEN (32 or 64), TAG_W (sideband tag width)
//   Ports:
//     clk, rst_n           clock, async active-low reset
//     in_valid/in_ready    instruction stream handshake
//     in_instr [32]        raw instruction word
//     in_tag [TAG_W]       opaque sideband, passed through unchanged
//     out_valid/out_ready  decoded stream handshake
//     out_imm [XLEN]       assembled, extended immediate (0 for R/ILL)
//     out_fmt              decoded format (imm_fmt_t)
//     out_tag [TAG_W]      tag of the beat
module imm_gen_pipe
  import rv_imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output imm_fmt_t         out_fmt,
  output logic [TAG_W-1:0] out_tag
);

  // RV64 shifts use a 6-bit shamt; RV32 only 5 bits.
  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;
  localparam int PAY_W   = XLEN + 3 + TAG_W;

  imm_fmt_t           dec_fmt;
  logic signed [31:0] raw32;
  logic [XLEN-1:0]    dec_imm;
  logic [PAY_W-1:0]   dec_payload;
  logic [PAY_W-1:0]   out_payload;

  // Format decode from the major opcode; OP-IMM splits on funct3 into
  // shifts (SLLI/SRLI/SRAI) and ordinary I-type immediates.
  always_comb begin
    dec_fmt = FMT_ILL;
    case (in_instr[6:0])
      OP_LOAD, OP_JALR, OP_SYSTEM: dec_fmt = FMT_I;
      OP_IMM:   dec_fmt = (in_instr[13:12] == 2'b01) ? FMT_ISH : FMT_I;
      OP_STORE:          dec_fmt = FMT_S;
      OP_BRANCH:         dec_fmt = FMT_B;
      OP_LUI, OP_AUIPC:  dec_fmt = FMT_U;
      OP_JAL:            dec_fmt = FMT_J;
      OP_REG:            dec_fmt = FMT_R;
      default:           dec_fmt = FMT_ILL;
    endcase
  end

  // Every signed format is first built as a sign-extended 32-bit value and
  // then widened with a signed cast, which covers U on RV64 as well.
  // Shifts bypass that path and zero-extend only the shamt, so funct7 bits
  // such as the SRAI selector never leak into the immediate.
  always_comb begin
    raw32   = '0;
    dec_imm = '0;
    case (dec_fmt)
      FMT_I: raw32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: raw32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: raw32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                      in_instr[11:8], 1'b0};
      FMT_U: raw32 = {in_instr[31:12], 12'b0};
      FMT_J: raw32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                      in_instr[30:21], 1'b0};
      default: raw32 = '0;
    endcase
    if (dec_fmt == FMT_ISH) begin
      dec_imm[SHAMT_W-1:0] = in_instr[20 +: SHAMT_W];
    end else begin
      dec_imm = XLEN'(raw32);
    end
  end

  assign dec_payload = {dec_imm, dec_fmt, in_tag};

  valid_ready_skid #(
    .W(PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign out_imm = out_payload[PAY_W-1 -: XLEN];
  assign out_fmt = imm_fmt_t'(out_payload[TAG_W +: 3]);
  assign out_tag = out_payload[TAG_W-1:0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe
//   Drives an XLEN=32 and an XLEN=64 instance from one shared stream.
//   Expected beats go into per-instance queues when a beat is accepted;
//   independent monitors pop and compare whenever an instance emits.
module tb_imm_gen_pipe;
  import rv_imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32;
  logic [31:0] out_imm32;
  imm_fmt_t    out_fmt32;
  logic [4:0]  out_tag32;

  logic        in_ready64, out_valid64;
  logic [63:0] out_imm64;
  imm_fmt_t    out_fmt64;
  logic [4:0]  out_tag64;

  int n_checks = 0;
  int n_pass   = 0;

  imm_beat_t q32[$];
  imm_beat_t q64[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_tag(out_tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_tag(out_tag64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("[TB] FAIL %s: got event, expected none", name);
  endtask

  // Reference model: field values from plain arithmetic, negative when the
  // top bit of the field is set, then truncated to the datapath width.
  function automatic imm_beat_t model(input logic [31:0] ins, input int xlen, input logic [4:0] tag);
    imm_beat_t m;
    longint    v;
    int        f3;
    imm_fmt_t  f;
    f3 = int'(ins[14:12]);
    v  = 0;
    case (ins[6:0])
      7'b0000011, 7'b1100111, 7'b1110011: f = FMT_I;
      7'b0010011: f = (f3 == 1 || f3 == 5) ? FMT_ISH : FMT_I;
      7'b0100011: f = FMT_S;
      7'b1100011: f = FMT_B;
      7'b0110111, 7'b0010111: f = FMT_U;
      7'b1101111: f = FMT_J;
      7'b0110011: f = FMT_R;
      default:    f = FMT_ILL;
    endcase
    case (f)
      FMT_I: begin
        v = longint'(ins[31:20]);
        if (v >= 2048) v = v - 4096;
      end
      FMT_ISH: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      FMT_S: begin
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (v >= 2048) v = v - 4096;
      end
      FMT_B: begin
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (v >= 4096) v = v - 8192;
      end
      FMT_U: begin
        v = longint'(ins[31:12]) * 4096;
        if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
      end
      FMT_J: begin
        v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
          + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (v >= 1048576) v = v - 2097152;
      end
      default: v = 0;
    endcase
    m.imm = 64'(v);
    if (xlen == 32) m.imm[63:32] = '0;
    m.fmt = f;
    m.tag = {3'b000, tag};
    return m;
  endfunction

  function automatic imm_beat_t mk(input logic [63:0] imm, input imm_fmt_t f, input logic [4:0] tag);
    imm_beat_t m;
    m.imm = imm;
    m.fmt = f;
    m.tag = {3'b000, tag};
    return m;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 10))
      0: r[6:0] = OP_LOAD;
      1: r[6:0] = OP_IMM;
      2: r[6:0] = OP_STORE;
      3: r[6:0] = OP_BRANCH;
      4: r[6:0] = OP_LUI;
      5: r[6:0] = OP_AUIPC;
      6: r[6:0] = OP_JAL;
      7: r[6:0] = OP_JALR;
      8: r[6:0] = OP_SYSTEM;
      9: r[6:0] = OP_REG;
      default: ;
    endcase
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic apply_stimulus(input logic [31:0] ins, input logic [4:0] tag,
                                input imm_beat_t e32, input imm_beat_t e64);
    in_valid = 1'b1;
    in_instr = ins;
    in_tag   = tag;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready32 && in_ready64) begin
        q32.push_back(e32);
        q64.push_back(e64);
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    fail_now("accept_timeout");
  endtask

  task automatic apply_directed(input logic [31:0] ins, input logic [4:0] tag,
                                input logic [63:0] imm64, input imm_fmt_t f);
    apply_stimulus(ins, tag, mk({32'h0, imm64[31:0]}, f, tag), mk(imm64, f, tag));
  endtask

  task automatic apply_random(input logic [31:0] ins, input logic [4:0] tag);
    apply_stimulus(ins, tag, model(ins, 32, tag), model(ins, 64, tag));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_q32_empty", 64'(q32.size()), 64'd0);
    check("drain_q64_empty", 64'(q64.size()), 64'd0);
  endtask

  // Monitors: compare every emitted beat against the head of its queue.
  always @(negedge clk) begin : mon32
    imm_beat_t e;
    if (rst_n && out_valid32 && out_ready) begin
      if (q32.size() == 0) fail_now("unexpected_beat32");
      else begin
        e = q32.pop_front();
        check("imm32", {32'h0, out_imm32}, e.imm);
        check("fmt32", 64'(out_fmt32), 64'(e.fmt));
        check("tag32", 64'(out_tag32), 64'(e.tag));
      end
    end
  end

  always @(negedge clk) begin : mon64
    imm_beat_t e;
    if (rst_n && out_valid64 && out_ready) begin
      if (q64.size() == 0) fail_now("unexpected_beat64");
      else begin
        e = q64.pop_front();
        check("imm64", out_imm64, e.imm);
        check("fmt64", 64'(out_fmt64), 64'(e.fmt));
        check("tag64", 64'(out_tag64), 64'(e.tag));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed vectors, backpressure, random, mid-run reset.
  initial begin
    logic rand_done;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    rand_done = 1'b0;

    #2;
    check("rst_in_ready32", 64'(in_ready32), 64'd1);
    check("rst_in_ready64", 64'(in_ready64), 64'd1);
    check("rst_out_valid32", 64'(out_valid32), 64'd0);
    check("rst_out_imm32", 64'(out_imm32), 64'd0);
    check("rst_out_fmt32", 64'(out_fmt32), 64'd0);
    check("rst_out_tag32", 64'(out_tag32), 64'd0);
    check("rst_out_valid64", 64'(out_valid64), 64'd0);
    #21 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(in_ready32), 64'd1);

    $display("[TB] directed vectors");
    apply_directed(32'hFFF00093, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I);
    check("latency_out_valid", 64'(out_valid32), 64'd1);
    apply_directed(32'hFE112E23, 5'd1, 64'hFFFF_FFFF_FFFF_FFFC, FMT_S);
    apply_directed(32'hFE000CE3, 5'd2, 64'hFFFF_FFFF_FFFF_FFF8, FMT_B);
    apply_directed(32'h0010006F, 5'd3, 64'h0000_0000_0000_0800, FMT_J);
    apply_directed(32'h123452B7, 5'd4, 64'h0000_0000_1234_5000, FMT_U);
    apply_directed(32'h41F0D093, 5'd5, 64'h0000_0000_0000_001F, FMT_ISH);
    apply_directed(32'h800002B7, 5'd6, 64'hFFFF_FFFF_8000_0000, FMT_U);
    apply_directed(32'h00000033, 5'h15, 64'h0, FMT_R);
    apply_directed(32'h0000007F, 5'h15, 64'h0, FMT_ILL);
    in_valid = 1'b0;
    drain();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    apply_directed(32'hFFF00093, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I);
    apply_directed(32'h123452B7, 5'd2, 64'h0000_0000_1234_5000, FMT_U);
    check("bp_in_ready_low", 64'(in_ready32), 64'd0);
    fork
      apply_directed(32'hFE112E23, 5'd3, 64'hFFFF_FFFF_FFFF_FFFC, FMT_S);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_hold_valid", 64'(out_valid32), 64'd1);
          check("bp_hold_tag", 64'(out_tag32), 64'd1);
          check("bp_hold_imm", 64'(out_imm32), 64'h0000_0000_FFFF_FFFF);
          check("bp_hold_ready", 64'(in_ready32), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    drain();

    $display("[TB] random traffic");
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          apply_random(rand_instr(), 5'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        in_valid  = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] reset with beats buffered");
    out_ready = 1'b0;
    apply_directed(32'h0010006F, 5'd9, 64'h800, FMT_J);
    apply_directed(32'hFE000CE3, 5'd10, 64'hFFFF_FFFF_FFFF_FFF8, FMT_B);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid32", 64'(out_valid32), 64'd0);
    check("midrst_out_valid64", 64'(out_valid64), 64'd0);
    check("midrst_in_ready32", 64'(in_ready32), 64'd1);
    check("midrst_out_tag32", 64'(out_tag32), 64'd0);
    q32.delete();
    q64.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("after_rst_in_ready32", 64'(in_ready32), 64'd1);
    check("after_rst_in_ready64", 64'(in_ready64), 64'd1);
    apply_directed(32'h0000007F, 5'd17, 64'h0, FMT_ILL);
    apply_directed(32'hFFF00093, 5'd18, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I);
    in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
